ntt_pair_former: RTL and testbench
==================================

# ntt_pair_former

Streaming pair former for one radix-2 NTT/INTT pipeline stage with butterfly span D = 2^SPAN_LOG. It accepts coefficients in natural order, one per valid cycle, and buffers the first D coefficients of each 2D block. It then emits each butterfly operand pair (x[k], x[k+D]) to the downstream butterfly/multiplier, together with the pair index that selects the twiddle factor. It sits directly upstream of the butterfly and modular-multiplier pipeline, which draws its delay buffers from the shared fifo controllers.

## Interface
- WIDTH, default 12: coefficient width in bits (Kyber 12, Dilithium 23).
- SPAN_LOG, default 0: log2 of the butterfly span D; legal range 0..7.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data carries a coefficient this cycle.
- in_data  input  WIDTH  coefficient.
- out_valid  output  1  out_a/out_b/out_idx hold a valid pair.
- out_a  output  WIDTH  x[k], the buffered (earlier) operand.
- out_b  output  WIDTH  x[k+D], the live (later) operand.
- out_idx  output  max(SPAN_LOG,1)  k mod D, the pair index within the block.
- out_last  output  1  marks the final pair of a 2D block (k = D-1).

## Operation
- Block counter cnt, SPAN_LOG+1 bits, resets to 0 and advances only on cycles where in_valid is high. It wraps from 2D-1 to 0.
- Fill phase, cnt[SPAN_LOG]=0: in_data is written to buffer slot cnt[SPAN_LOG-1:0]. No output is produced.
- Pair phase, cnt[SPAN_LOG]=1: the slot at cnt[SPAN_LOG-1:0] is read.
  - out_a receives the stored value; out_b receives the registered in_data.
  - out_idx receives the slot index; out_last = (slot index == D-1).
- The slot read in pair phase is rewritten by the next block's fill phase. There is never a same-slot read and write in one cycle, because the phases alternate.
- Gaps in in_valid are allowed anywhere, including mid-fill and mid-pair. The counter and buffer hold their state during gaps, and no pair is emitted.
- SPAN_LOG=0, D=1: the buffer degenerates to a single register. Even-indexed valid inputs fill it and odd-indexed valid inputs emit a pair. out_idx is constant 0 and out_last is 1 on every pair.
- There is no backpressure. The downstream stage must accept one pair per cycle. Input rate is at most one coefficient per cycle, so output rate is at most one pair per two inputs.
- Reset values: out_valid=0, out_a=0, out_b=0, out_idx=0, out_last=0, cnt=0. Buffer contents are don't-care after reset and are never output before being rewritten.
- Reset asserted mid-block discards the partial block. The first valid input after reset release is treated as x[0] of a new block.

## Timing
- Latency is 1 cycle: a pair-phase input accepted at edge t gives out_valid=1 in the cycle after edge t.
- out_valid is high for exactly one cycle per pair-phase valid input, and low in every other cycle.
- Buffer read is registered, matching the 1-cycle output register. in_data is pipelined one stage so that out_a and out_b align.
- rst takes effect at the next rising edge and overrides in_valid in that cycle.

## Structure
- The shared package holds the WIDTH constants per scheme (KYBER_Q_BITS=12, DILITHIUM_Q_BITS=23) and the SPAN_LOG per stage index (stage i uses SPAN_LOG = NTT_STAGE_CNT-1-i for NTT and i for INTT).
- Sub-module: reuse the existing dp_ram (WIDTH, SIZE=D) as the buffer. For D=1, use a plain register.
- Counter, phase decode, in_data delay register and output registers all live in the top module.

## Test plan
- WIDTH=12, SPAN_LOG=2, continuous valid, inputs 0..7: pairs (0,4) idx0, (1,5) idx1, (2,6) idx2, (3,7) idx3 with out_last. Each appears 1 cycle after inputs 4..7.
- Same configuration, 16 continuous inputs 0..15: second block gives (8,12)..(11,15). Checks wrap-around and buffer reuse.
- SPAN_LOG=2 with in_valid toggled 1,0,1,0,…: same pair values as the first test, and out_valid pulses only after valid pair-phase inputs.
- SPAN_LOG=0, inputs 10,20,30,40: pairs (10,20) and (30,40), out_idx=0 and out_last=1 on both.
- SPAN_LOG=3, rst pulsed after 5 inputs, then inputs 100..115: first pair is (100,108). No output is derived from pre-reset data, and all outputs are 0 during reset.
- WIDTH=23, SPAN_LOG=7, random data for 512 inputs: a scoreboard checks out_a=x[k], out_b=x[k+128] and out_idx=k for every pair.

Source files
------------

// File: rtl/ntt_pair_former_pkg.sv
// Shared constants for the NTT pair former: coefficient widths per scheme and
// per-stage butterfly span selection.
package ntt_pair_former_pkg;

    localparam int unsigned KYBER_Q_BITS     = 12;
    localparam int unsigned DILITHIUM_Q_BITS = 23;
    localparam int unsigned NTT_STAGE_CNT    = 8;
    localparam int unsigned MAX_SPAN_LOG     = 7;

    // NTT stages shrink the span as they go, INTT stages grow it.
    function automatic int unsigned stage_span_log(input int unsigned stage, input logic inverse);
        return inverse ? stage : (NTT_STAGE_CNT - 1 - stage);
    endfunction

endpackage

// File: rtl/ntt_pair_former_dp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module dp_ram #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned SIZE  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  we,
    input  logic [(SIZE > 1 ? $clog2(SIZE) : 1)-1:0] waddr,
    input  logic [WIDTH-1:0]                      wdata,
    input  logic                                  re,
    input  logic [(SIZE > 1 ? $clog2(SIZE) : 1)-1:0] raddr,
    output logic [WIDTH-1:0]                      rdata
);

    logic [WIDTH-1:0] mem_q [SIZE];
    logic [WIDTH-1:0] rdata_q;

    // Storage carries no reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ntt_pair_former.sv
// Streaming pair former: buffers the first D coefficients of each 2D block and
// emits (x[k], x[k+D]) pairs with the twiddle index k one cycle after x[k+D].
module ntt_pair_former
    import ntt_pair_former_pkg::*;
#(
    parameter int unsigned WIDTH    = KYBER_Q_BITS,
    parameter int unsigned SPAN_LOG = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    input  logic [WIDTH-1:0]                       in_data,
    output logic                                   out_valid,
    output logic [WIDTH-1:0]                       out_a,
    output logic [WIDTH-1:0]                       out_b,
    output logic [(SPAN_LOG > 0 ? SPAN_LOG : 1)-1:0] out_idx,
    output logic                                   out_last
);

    localparam int unsigned D     = 1 << SPAN_LOG;
    localparam int unsigned CNT_W = SPAN_LOG + 1;
    localparam int unsigned IDX_W = (SPAN_LOG > 0) ? SPAN_LOG : 1;

    if (SPAN_LOG > MAX_SPAN_LOG) begin : g_bad_span
        $error("ntt_pair_former: SPAN_LOG out of range");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] slot;
    logic             pair_phase;
    logic             fill_acc;
    logic             pair_acc;

    logic             valid_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx_q;
    logic             last_q;
    logic [WIDTH-1:0] a_rd;

    assign pair_phase = cnt_q[CNT_W-1];
    assign fill_acc   = in_valid && !rst && !pair_phase;
    assign pair_acc   = in_valid && pair_phase;

    // Counter wraps naturally at 2D because CNT_W = SPAN_LOG+1.
    always_comb begin
        cnt_d = cnt_q;
        if (in_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    if (SPAN_LOG == 0) begin : g_reg_buf
        logic [WIDTH-1:0] buf_q;
        logic [WIDTH-1:0] a_q;

        assign slot = '0;

        always_ff @(posedge clk) begin
            if (fill_acc) begin
                buf_q <= in_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                a_q <= '0;
            end else if (pair_acc) begin
                a_q <= buf_q;
            end
        end

        assign a_rd = a_q;
    end else begin : g_ram_buf
        assign slot = IDX_W'(cnt_q);

        dp_ram #(
            .WIDTH (WIDTH),
            .SIZE  (D)
        ) u_buf (
            .clk   (clk),
            .rst   (rst),
            .we    (fill_acc),
            .waddr (slot),
            .wdata (in_data),
            .re    (pair_acc),
            .raddr (slot),
            .rdata (a_rd)
        );
    end

    // Live operand and pair metadata, aligned with the registered buffer read.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            b_q     <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= pair_acc;
            if (pair_acc) begin
                b_q    <= in_data;
                idx_q  <= slot;
                last_q <= (slot == IDX_W'(D - 1));
            end
        end
    end

    assign out_valid = valid_q;
    assign out_a     = a_rd;
    assign out_b     = b_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_ntt_pair_former.sv
// Scoreboard bench for ntt_pair_former across four span/width configurations.
module tb_ntt_pair_former;
    import ntt_pair_former_pkg::*;

    localparam int unsigned SPAN_BIG = stage_span_log(0, 1'b0);

    typedef struct packed {
        logic [1:0]  sel;
        logic [22:0] a;
        logic [22:0] b;
        logic [6:0]  idx;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  vld;
    logic [22:0] din [4];

    int n_checks = 0;
    int n_errors = 0;

    exp_t        sb_q [$];
    int unsigned span_of [4] = '{0, 2, 3, SPAN_BIG};
    int unsigned m_cnt [4];
    logic [22:0] m_buf [4][128];

    logic        ov0, ov1, ov2, ov3;
    logic [11:0] a0, b0, a1, b1, a2, b2;
    logic [22:0] a3, b3;
    logic [0:0]  i0;
    logic [1:0]  i1;
    logic [2:0]  i2;
    logic [SPAN_BIG-1:0] i3;
    logic        l0, l1, l2, l3;

    ntt_pair_former #(.WIDTH(KYBER_Q_BITS), .SPAN_LOG(0)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_data(din[0][11:0]),
        .out_valid(ov0), .out_a(a0), .out_b(b0), .out_idx(i0), .out_last(l0));
    ntt_pair_former #(.WIDTH(KYBER_Q_BITS), .SPAN_LOG(2)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_data(din[1][11:0]),
        .out_valid(ov1), .out_a(a1), .out_b(b1), .out_idx(i1), .out_last(l1));
    ntt_pair_former #(.WIDTH(KYBER_Q_BITS), .SPAN_LOG(3)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_data(din[2][11:0]),
        .out_valid(ov2), .out_a(a2), .out_b(b2), .out_idx(i2), .out_last(l2));
    ntt_pair_former #(.WIDTH(DILITHIUM_Q_BITS), .SPAN_LOG(SPAN_BIG)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(vld[3]), .in_data(din[3]),
        .out_valid(ov3), .out_a(a3), .out_b(b3), .out_idx(i3), .out_last(l3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mon(input int sel, input logic v, input logic [22:0] a, input logic [22:0] b,
                       input logic [6:0] idx, input logic last);
        exp_t e;
        if (v === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk($sformatf("unexpected_pair_d%0d", sel), 64'(v), 64'(0));
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("pair_src_d%0d", sel), 64'(sel), 64'(e.sel));
                chk($sformatf("out_a_d%0d", sel), 64'(a), 64'(e.a));
                chk($sformatf("out_b_d%0d", sel), 64'(b), 64'(e.b));
                chk($sformatf("out_idx_d%0d", sel), 64'(idx), 64'(e.idx));
                chk($sformatf("out_last_d%0d", sel), 64'(last), 64'(e.last));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, ov0, 23'(a0), 23'(b0), 7'(i0), l0);
            mon(1, ov1, 23'(a1), 23'(b1), 7'(i1), l1);
            mon(2, ov2, 23'(a2), 23'(b2), 7'(i2), l2);
            mon(3, ov3, a3, b3, 7'(i3), l3);
        end
    end

    // Reference model: fill a block buffer, then predict one pair per pair-phase input.
    task automatic model(input int sel, input logic [22:0] d);
        int unsigned dd;
        int unsigned k;
        exp_t e;
        dd = 1 << span_of[sel];
        if (m_cnt[sel] < dd) begin
            m_buf[sel][m_cnt[sel]] = d;
        end else begin
            k      = m_cnt[sel] - dd;
            e.sel  = 2'(sel);
            e.a    = m_buf[sel][k];
            e.b    = d;
            e.idx  = 7'(k);
            e.last = (k == dd - 1);
            sb_q.push_back(e);
        end
        m_cnt[sel] = (m_cnt[sel] + 1) % (2 * dd);
    endtask

    task automatic drive(input int sel, input logic v, input logic [22:0] d);
        @(posedge clk);
        #1;
        vld      = '0;
        din[sel] = d;
        vld[sel] = v;
        if (v) model(sel, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            vld = '0;
        end
    endtask

    task automatic drain(input string tag);
        idle(3);
        chk(tag, 64'(sb_q.size()), 64'(0));
        sb_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        vld = '0;
        for (int i = 0; i < 4; i++) begin
            din[i]   = '0;
            m_cnt[i] = 0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_d0", 64'({ov0, a0, b0, i0, l0}), 64'(0));
        chk("rst_d1", 64'({ov1, a1, b1, i1, l1}), 64'(0));
        chk("rst_d2", 64'({ov2, a2, b2, i2, l2}), 64'(0));
        chk("rst_d3", {ov3, a3, b3, 7'(i3), l3}, 64'(0));
        rst = 1'b0;

        // Span 4, continuous 0..7.
        for (int i = 0; i < 8; i++) drive(1, 1'b1, 23'(i));
        drain("drain_cont8");

        // Span 4, two blocks back to back.
        for (int i = 0; i < 16; i++) drive(1, 1'b1, 23'(i));
        drain("drain_cont16");

        // Span 4, valid toggling every cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1, 1'b1, 23'(i));
            drive(1, 1'b0, 23'h0abc);
        end
        drain("drain_toggle");

        // Span 1: single-register buffer.
        drive(0, 1'b1, 23'd10);
        drive(0, 1'b1, 23'd20);
        drive(0, 1'b0, 23'd99);
        drive(0, 1'b1, 23'd30);
        drive(0, 1'b1, 23'd40);
        drain("drain_span1");

        // Span 8: partial block discarded by reset, which also overrides in_valid.
        for (int i = 0; i < 5; i++) drive(2, 1'b1, 23'(50 + i));
        @(posedge clk);
        #1;
        rst     = 1'b1;
        vld     = 4'b0100;
        din[2]  = 23'd999;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        @(posedge clk);
        #1;
        chk("midrst_d2", 64'({ov2, a2, b2, i2, l2}), 64'(0));
        rst = 1'b0;
        vld = '0;
        for (int i = 0; i < 16; i++) drive(2, 1'b1, 23'(100 + i));
        drain("drain_rst");

        // Span 128, wide random data with occasional gaps.
        for (int i = 0; i < 512; i++) begin
            if ($urandom_range(0, 7) == 0) drive(3, 1'b0, 23'($urandom));
            drive(3, 1'b1, 23'($urandom));
        end
        drain("drain_random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
